// File: rtl/cam_img_pkg.sv
// cam_img_pkg: shared constants for the image-CAM sequencer.
//  KEY_W_DEF / TAG_W_DEF : default key (pixel) and tag widths
//  TAG_EMPTY             : tag value the CAM treats as "no entry"
//  TAG_MAX               : last usable tag at the default width
//  ST_* / state_e        : sequencer FSM encoding
package cam_img_pkg;

  localparam int KEY_W_DEF = 24;
  localparam int TAG_W_DEF = 14;

  localparam logic [TAG_W_DEF-1:0] TAG_EMPTY = '0;
  localparam logic [TAG_W_DEF-1:0] TAG_MAX   = '1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_QUERY = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    QUERY = ST_QUERY,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/cam_match_align.sv
// cam_match_align: realigns the CAM match bit with the query that caused it.
//  A token enters on each accepted query and walks a MATCH_LAT-deep shift
//  pipe; when it reaches the end the CAM's match output belongs to it.
// Ports:
//  clk, rst   clock, synchronous active-high reset (clears tokens in flight)
//  tok_in     query accepted this cycle
//  cam_match  CAM match result (valid MATCH_LAT cycles after the lookup)
//  r_valid    result strobe, one cycle per query
//  r_hit      match bit qualified by r_valid
module cam_match_align #(
  parameter int MATCH_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tok_in,
  input  logic cam_match,
  output logic r_valid,
  output logic r_hit
);

  // vld_pipe[k] = a token entered k cycles ago
  logic [MATCH_LAT:1] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= tok_in;
      for (int i = 2; i <= MATCH_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign r_valid = vld_pipe[MATCH_LAT];
  // gate so a stale match bit never leaks out between results
  assign r_hit   = vld_pipe[MATCH_LAT] & cam_match;

endmodule

// File: rtl/cam_img_seq.sv
// cam_img_seq: upstream sequencer for the image CAM.
//  LOAD  : each accepted pixel is written as a key with an auto-incremented tag.
//  QUERY : each accepted pixel is looked up; the match bit is realigned and
//          returned as a hit/miss result stream.
// Ports:
//  clk, rst                 clock, synchronous active-high reset
//  start, mode              pass start pulse (IDLE only), 0=LOAD 1=QUERY
//  s_valid/s_ready/s_pixel/s_last   pixel stream handshake
//  cam_we, cam_match_en, cam_addr, cam_din, cam_match   CAM interface
//  r_valid, r_hit           per-query result (no backpressure)
//  busy, done, full         status; full is sticky until rst
//  hit_count                hits in the current query pass
// Build option: define CAM_SEQ_STATS_EN to maintain hit_count; otherwise it
//  is tied to 0 and no counter exists.
module cam_img_seq
  import cam_img_pkg::*;
#(
  parameter int KEY_W     = KEY_W_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int MATCH_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [KEY_W-1:0] s_pixel,
  input  logic             s_last,
  output logic             cam_we,
  output logic             cam_match_en,
  output logic [KEY_W-1:0] cam_addr,
  output logic [TAG_W-1:0] cam_din,
  input  logic             cam_match,
  output logic             r_valid,
  output logic             r_hit,
  output logic             busy,
  output logic             done,
  output logic             full,
  output logic [TAG_W-1:0] hit_count
);

  localparam logic [TAG_W-1:0] TAG_TOP   = (TAG_W == TAG_W_DEF) ? TAG_W'(TAG_MAX)
                                                                : {TAG_W{1'b1}};
  localparam logic [TAG_W-1:0] TAG_FIRST = TAG_W'(TAG_EMPTY) + TAG_W'(1);
  localparam logic [1:0]       DRAIN_END = 2'(MATCH_LAT - 1);

  state_e           state, state_nx;
  logic [TAG_W-1:0] next_tag;
  logic [KEY_W-1:0] addr_q;
  logic [TAG_W-1:0] din_q;
  logic [1:0]       drain_cnt;
  logic             hs, ld_hs, q_hs, q_start;

  // ---------------- handshake / CAM drive ----------------
  assign s_ready = ((state == LOAD) && !full) || (state == QUERY);
  assign hs      = s_valid & s_ready;
  assign ld_hs   = hs & (state == LOAD);
  assign q_hs    = hs & (state == QUERY);
  assign q_start = (state == IDLE) & start & mode;

  assign cam_we       = ld_hs;
  assign cam_match_en = q_hs;
  // CAM bus follows the pixel during a handshake, otherwise holds its last value
  assign cam_addr     = hs    ? s_pixel  : addr_q;
  assign cam_din      = ld_hs ? next_tag : din_q;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (mode)      state_nx = QUERY;
          else if (full) state_nx = DONE;  // nothing left to write
          else           state_nx = LOAD;
        end
      end
      // writing the last tag ends the pass even without s_last; both at once
      // still yield a single DONE
      LOAD:  if (full || (ld_hs && (s_last || next_tag == TAG_TOP))) state_nx = DONE;
      QUERY: if (q_hs && s_last) state_nx = DRAIN;
      // hold until the final query's result has come out
      DRAIN: if (drain_cnt == DRAIN_END) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      next_tag  <= TAG_FIRST;
      full      <= 1'b0;
      addr_q    <= '0;
      din_q     <= TAG_W'(TAG_EMPTY);
      drain_cnt <= '0;
    end else begin
      if (hs) addr_q <= s_pixel;
      if (ld_hs) begin
        din_q <= next_tag;
        if (next_tag == TAG_TOP) full     <= 1'b1;
        else                     next_tag <= next_tag + 1'b1;
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                drain_cnt <= '0;
    end
  end

  // ---------------- result realignment ----------------
  cam_match_align #(.MATCH_LAT(MATCH_LAT)) u_align (
    .clk       (clk),
    .rst       (rst),
    .tok_in    (q_hs),
    .cam_match (cam_match),
    .r_valid   (r_valid),
    .r_hit     (r_hit)
  );

  // ---------------- stats ----------------
`ifdef CAM_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || q_start)
      hit_count <= '0;
    else if (r_valid && r_hit && hit_count != TAG_TOP)
      hit_count <= hit_count + 1'b1;
  end
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_cam_img_seq.sv
module tb_cam_img_seq;
  localparam int KEY_W   = 24;
  localparam int TAG_W   = 14;
  localparam int LAT     = 1;
  localparam int TAG_TOP = (1 << TAG_W) - 1;

  logic             clk = 1'b0;
  logic             rst, start, mode, s_valid, s_last;
  logic [KEY_W-1:0] s_pixel;
  logic             s_ready, cam_we, cam_match_en, cam_match;
  logic [KEY_W-1:0] cam_addr;
  logic [TAG_W-1:0] cam_din, hit_count;
  logic             r_valid, r_hit, busy, done, full;

  cam_img_seq #(.KEY_W(KEY_W), .TAG_W(TAG_W), .MATCH_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel), .s_last(s_last),
    .cam_we(cam_we), .cam_match_en(cam_match_en), .cam_addr(cam_addr),
    .cam_din(cam_din), .cam_match(cam_match),
    .r_valid(r_valid), .r_hit(r_hit), .busy(busy), .done(done), .full(full),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- CAM emulation (environment) ----------------
  logic [KEY_W-1:0] cam_key [TAG_TOP+1];
  bit               cam_v   [TAG_TOP+1];
  bit   [LAT-1:0]   mdly;

  function automatic bit cam_lookup(input logic [KEY_W-1:0] k);
    for (int i = 1; i <= TAG_TOP; i++) if (cam_v[i] && cam_key[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (cam_we) begin
      cam_key[cam_din] <= cam_addr;
      cam_v[cam_din]   <= 1'b1;
    end
    if (cam_match_en) mdly[0] <= cam_lookup(cam_addr);
    else              mdly[0] <= 1'b0;
    for (int i = 1; i < LAT; i++) mdly[i] <= mdly[i-1];
  end
  assign cam_match = mdly[LAT-1];

  // ---------------- reference model ----------------
  typedef struct { int due; bit hit; } exp_t;
  exp_t exp_q[$];
  bit   loaded [int unsigned];
  int   tag_exp  = 1;
  bit   full_exp = 0;
  int   hits_exp = 0;
  bit   mon_en   = 0;

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      chk("we_match_excl", {31'd0, cam_we & cam_match_en}, 0);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("r_valid", {31'd0, r_valid}, 1);
        chk("r_hit", {31'd0, r_hit}, {31'd0, exp_q[0].hit});
        void'(exp_q.pop_front());
      end else begin
        chk("r_valid_idle", {31'd0, r_valid}, 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    @(negedge clk); start = 0; s_valid = 0; s_last = 0; #1;
  endtask

  task automatic pulse_start(input bit m);
    @(negedge clk); start = 1; mode = m; s_valid = 0; s_last = 0; #1;
    chk("idle_busy", {31'd0, busy}, 0);
    if (m) hits_exp = 0;
  endtask

  task automatic load_px(input logic [KEY_W-1:0] px, input bit last, input bit st);
    bit acc;
    @(negedge clk); start = st; mode = st; s_valid = 1; s_pixel = px; s_last = last; #1;
    acc = !full_exp;
    chk("ld_ready", {31'd0, s_ready}, {31'd0, acc});
    if (acc) begin
      chk("ld_we", {31'd0, cam_we}, 1);
      chk("ld_din", 32'(cam_din), tag_exp);
      chk("ld_addr", 32'(cam_addr), 32'(px));
      chk("ld_done", {31'd0, done}, 0);
      loaded[32'(px)] = 1'b1;
      if (tag_exp == TAG_TOP) full_exp = 1; else tag_exp++;
    end else begin
      chk("ld_we_blocked", {31'd0, cam_we}, 0);
    end
  endtask

  task automatic query_px(input logic [KEY_W-1:0] px, input bit last);
    exp_t e;
    @(negedge clk); start = 0; s_valid = 1; s_pixel = px; s_last = last; #1;
    chk("q_ready", {31'd0, s_ready}, 1);
    chk("q_match_en", {31'd0, cam_match_en}, 1);
    chk("q_addr", 32'(cam_addr), 32'(px));
    e.due = cyc + LAT;
    e.hit = loaded.exists(32'(px));
    if (e.hit && hits_exp < TAG_TOP) hits_exp++;
    exp_q.push_back(e);
  endtask

  task automatic pass_end();
    drive_idle();
    chk("done_pulse", {31'd0, done}, 1);
    chk("done_busy", {31'd0, busy}, 1);
    drive_idle();
    chk("done_clear", {31'd0, done}, 0);
    chk("idle_after", {31'd0, busy}, 0);
  endtask

  task automatic query_end();
    for (int i = 0; i < LAT; i++) begin
      drive_idle();
      chk("drain_done", {31'd0, done}, 0);
      chk("drain_busy", {31'd0, busy}, 1);
    end
    pass_end();
`ifdef CAM_SEQ_STATS_EN
    chk("hit_count", 32'(hit_count), hits_exp);
`else
    chk("hit_count_off", 32'(hit_count), 0);
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 0);
    chk({tag, "_we"}, {31'd0, cam_we}, 0);
    chk({tag, "_men"}, {31'd0, cam_match_en}, 0);
    chk({tag, "_addr"}, 32'(cam_addr), 0);
    chk({tag, "_din"}, 32'(cam_din), 0);
    chk({tag, "_rv"}, {31'd0, r_valid}, 0);
    chk({tag, "_rh"}, {31'd0, r_hit}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_full"}, {31'd0, full}, 0);
    chk({tag, "_hits"}, 32'(hit_count), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [KEY_W-1:0] t1 [6];
    logic [KEY_W-1:0] px, pa, pb, pc;
    t1[0] = 24'hFFEE11; t1[1] = 24'hAACB01; t1[2] = 24'hABCDEF;
    t1[3] = 24'h987654; t1[4] = 24'h156799; t1[5] = 24'h112233;
    rst = 1; start = 0; mode = 0; s_valid = 0; s_pixel = '0; s_last = 0;
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk); rst = 0; mon_en = 1;

    // 1: LOAD six pixels, tags 1..6
    pulse_start(0);
    for (int i = 0; i < 6; i++) load_px(t1[i], i == 5, 0);
    pass_end();

    // 2: back-to-back QUERY
    pulse_start(1);
    query_px(24'hFFEE11, 0);
    query_px(24'hAACB01, 0);
    query_px(24'h112233, 0);
    query_px(24'h123456, 1);
    query_end();

    // 3: gapped QUERY, mixed loaded / random pixels
    pulse_start(1);
    for (int i = 0; i < 8; i++) begin
      px = ($urandom_range(0, 1) == 1) ? t1[$urandom_range(0, 5)] : KEY_W'($urandom);
      query_px(px, i == 7);
      if (i != 7) begin
        drive_idle();
        chk("gap_men", {31'd0, cam_match_en}, 0);
        chk("gap_addr_hold", 32'(cam_addr), 32'(px));
      end
    end
    query_end();

    // random back-to-back QUERY
    pulse_start(1);
    for (int i = 0; i < 10; i++) begin
      px = ($urandom_range(0, 2) != 0) ? t1[$urandom_range(0, 5)] : KEY_W'($urandom);
      query_px(px, i == 9);
    end
    query_end();

    // 6: start pulses during LOAD are ignored
    pulse_start(0);
    load_px(KEY_W'($urandom), 0, 0);
    load_px(KEY_W'($urandom), 0, 1);
    load_px(KEY_W'($urandom), 0, 1);
    load_px(KEY_W'($urandom), 1, 0);
    pass_end();

    // bulk LOAD up to tag TAG_TOP-2
    pulse_start(0);
    while (tag_exp != TAG_TOP - 1)
      load_px(KEY_W'(24'h800000 + tag_exp), tag_exp == TAG_TOP - 2, 0);
    pass_end();
    chk("bulk_next_tag", tag_exp, TAG_TOP - 1);

    // 4: tag exhaustion
    pa = 24'h0A0A0A; pb = 24'h0B0B0B; pc = 24'h0C0C0C;
    pulse_start(0);
    load_px(pa, 0, 0);
    load_px(pb, 0, 0);
    load_px(pc, 1, 0);
    chk("full_done", {31'd0, done}, 1);
    chk("full_set", {31'd0, full}, 1);
    drive_idle();
    chk("full_done_once", {31'd0, done}, 0);
    chk("full_sticky", {31'd0, full}, 1);
    pulse_start(0);
    drive_idle();
    chk("full_load_done", {31'd0, done}, 1);
    chk("full_load_ready", {31'd0, s_ready}, 0);
    drive_idle();
    chk("full_load_idle", {31'd0, done}, 0);

    // queries still served while full
    pulse_start(1);
    query_px(24'h800064, 0);
    query_px(pc, 0);
    query_px(pb, 0);
    query_px(24'h112233, 1);
    query_end();

    // 5: reset mid-QUERY with tokens in flight
    pulse_start(1);
    query_px(t1[0], 0);
    @(negedge clk); s_valid = 1; s_pixel = t1[1]; s_last = 0; rst = 1; #1;
    while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    @(negedge clk); s_valid = 0; #1;
    check_zero("mid_rst");
    @(negedge clk); rst = 0; #1;
    hits_exp = 0;
    drive_idle();
    chk("rst_no_done", {31'd0, done}, 0);
    chk("rst_no_valid", {31'd0, r_valid}, 0);
    pulse_start(1);
    query_px(t1[2], 0);
    query_px(24'h123456, 0);
    query_px(t1[5], 1);
    query_end();

    repeat (3) drive_idle();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
